// File: rtl/car_alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : car_alarm_pkg
// Purpose  : Shared definitions for the car alarm controller: state encoding,
//            state width and the counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package car_alarm_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } alarmState_t;

    // Bits needed to hold the values 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        int w;
        w = $clog2(maxVal + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/car_alarm_controller_debounce.sv
`default_nettype none
// ============================================================================
// Module   : alarm_debounce
// Purpose  : Single-bit debouncer. The stable output takes a new level only
//            after the raw input has disagreed with it on DEBOUNCE_CYCLES
//            consecutive sampling edges; any agreeing sample restarts the
//            count.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous, active-high
//            raw    - undebounced input
//            stable - debounced level (0 after reset)
// Revision : 1.0 - initial release
// ============================================================================
module alarm_debounce
    import car_alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int                 c_CNT_W = cntWidth(DEBOUNCE_CYCLES);
    // Count value reached after DEBOUNCE_CYCLES-1 disagreeing samples; the
    // next disagreeing sample is the one that commits the new level.
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (raw == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt >= c_LAST) begin
            r_stable <= raw;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + c_CNT_W'(1);
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/car_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : car_alarm_controller
// Purpose  : Debounced lights-left-on warning plus an arm/disarm intrusion
//            state machine with an entry delay and a timed siren.
// Ports    : clk              - clock, rising edge
//            reset            - asynchronous, active-high
//            CarLightsOnSign  - raw headlights switch
//            OpenDoorSign     - raw door switches, one bit per door
//            IgnitionSignalOn - raw ignition switch
//            ArmRequest       - one-cycle arm pulse
//            DisarmRequest    - one-cycle disarm pulse (wins over arm)
//            CarAlarmSignal   - registered lights-left-on warning
//            SirenOn          - siren drive (state == ALARM)
//            Armed            - high in ARMED, ENTRY and ALARM
//            AlarmState       - current state code
// Revision : 1.0 - initial release
// ============================================================================
module car_alarm_controller
    import car_alarm_pkg::*;
#(
    parameter int NUM_DOORS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTRY_DELAY     = 16,
    parameter int SIREN_TIME      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CarLightsOnSign,
    input  logic [NUM_DOORS-1:0] OpenDoorSign,
    input  logic                 IgnitionSignalOn,
    input  logic                 ArmRequest,
    input  logic                 DisarmRequest,
    output logic                 CarAlarmSignal,
    output logic                 SirenOn,
    output logic                 Armed,
    output logic [c_STATE_W-1:0] AlarmState
);

    localparam int c_NUM_IN  = NUM_DOORS + 2;
    localparam int c_LIGHTS  = NUM_DOORS;
    localparam int c_IGN     = NUM_DOORS + 1;
    localparam int c_ENTRY_W = cntWidth(ENTRY_DELAY);
    localparam int c_SIREN_W = cntWidth(SIREN_TIME);

    localparam logic [c_ENTRY_W-1:0] c_ENTRY_LOAD = c_ENTRY_W'(ENTRY_DELAY);
    localparam logic [c_SIREN_W-1:0] c_SIREN_LOAD = c_SIREN_W'(SIREN_TIME);

    // ------------------------------------------------------------------
    // Input debouncing: doors in the low bits, then lights, then ignition.
    // ------------------------------------------------------------------
    logic [c_NUM_IN-1:0] w_rawIn;
    logic [c_NUM_IN-1:0] w_dbIn;

    assign w_rawIn = {IgnitionSignalOn, CarLightsOnSign, OpenDoorSign};

    for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_debounce
        alarm_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (w_rawIn[gi]),
            .stable(w_dbIn[gi])
        );
    end

    logic w_anyDoor;
    logic w_lights;
    logic w_ign;
    logic w_intrusion;

    assign w_anyDoor   = |w_dbIn[NUM_DOORS-1:0];
    assign w_lights    = w_dbIn[c_LIGHTS];
    assign w_ign       = w_dbIn[c_IGN];
    assign w_intrusion = w_anyDoor | w_ign;

    // ------------------------------------------------------------------
    // Lights-left-on warning, independent of the intrusion state machine.
    // ------------------------------------------------------------------
    logic r_carAlarm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carAlarm <= 1'b0;
        end else begin
            r_carAlarm <= w_lights & w_anyDoor & ~w_ign;
        end
    end

    assign CarAlarmSignal = r_carAlarm;

    // ------------------------------------------------------------------
    // Intrusion state machine with entry and siren down-counters.
    // ------------------------------------------------------------------
    alarmState_t          r_state;
    alarmState_t          w_stateNext;
    logic [c_ENTRY_W-1:0] r_entryCnt;
    logic [c_ENTRY_W-1:0] w_entryCntNext;
    logic [c_SIREN_W-1:0] r_sirenCnt;
    logic [c_SIREN_W-1:0] w_sirenCntNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= DISARMED;
            r_entryCnt <= '0;
            r_sirenCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_entryCnt <= w_entryCntNext;
            r_sirenCnt <= w_sirenCntNext;
        end
    end

    // Counters are loaded with the full delay on entry to their state and
    // the state is left at the edge where the counter reads 1, so the state
    // lasts exactly the loaded number of cycles. Testing <= 1 also keeps a
    // zero count from wrapping.
    always_comb begin
        w_stateNext    = r_state;
        w_entryCntNext = r_entryCnt;
        w_sirenCntNext = r_sirenCnt;
        case (r_state)
            DISARMED: begin
                if (ArmRequest && !DisarmRequest && !w_intrusion) begin
                    w_stateNext = ARMED;
                end
            end
            ARMED: begin
                if (DisarmRequest) begin
                    w_stateNext = DISARMED;
                end else if (w_intrusion) begin
                    w_stateNext    = ENTRY;
                    w_entryCntNext = c_ENTRY_LOAD;
                end
            end
            ENTRY: begin
                if (DisarmRequest) begin
                    w_stateNext    = DISARMED;
                    w_entryCntNext = '0;
                end else if (r_entryCnt <= c_ENTRY_W'(1)) begin
                    w_stateNext    = ALARM;
                    w_entryCntNext = '0;
                    w_sirenCntNext = c_SIREN_LOAD;
                end else begin
                    w_entryCntNext = r_entryCnt - c_ENTRY_W'(1);
                end
            end
            ALARM: begin
                if (DisarmRequest) begin
                    w_stateNext    = DISARMED;
                    w_sirenCntNext = '0;
                end else if (r_sirenCnt <= c_SIREN_W'(1)) begin
                    w_stateNext    = ARMED;
                    w_sirenCntNext = '0;
                end else begin
                    w_sirenCntNext = r_sirenCnt - c_SIREN_W'(1);
                end
            end
            default: begin
                w_stateNext = DISARMED;
            end
        endcase
    end

    // Straight decodes of the state register: these follow an asynchronous
    // reset immediately and carry no extra latency.
    assign SirenOn    = (r_state == ALARM);
    assign Armed      = (r_state != DISARMED);
    assign AlarmState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_car_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_alarm_controller
// Purpose  : Directed self-checking bench for car_alarm_controller with the
//            default parameters (4 doors, debounce 4, entry 16, siren 64).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_alarm_controller;

    logic       clk;
    logic       reset;
    logic       lights;
    logic [3:0] doors;
    logic       ign;
    logic       armReq;
    logic       disarmReq;
    logic       carAlarm;
    logic       siren;
    logic       armed;
    logic [1:0] state;

    int checkCnt;
    int passCnt;

    car_alarm_controller #(
        .NUM_DOORS      (4),
        .DEBOUNCE_CYCLES(4),
        .ENTRY_DELAY    (16),
        .SIREN_TIME     (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .CarLightsOnSign (lights),
        .OpenDoorSign    (doors),
        .IgnitionSignalOn(ign),
        .ArmRequest      (armReq),
        .DisarmRequest   (disarmReq),
        .CarAlarmSignal  (carAlarm),
        .SirenOn         (siren),
        .Armed           (armed),
        .AlarmState      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic pulse(input logic a, input logic d);
        armReq    = a;
        disarmReq = d;
        tick();
        armReq    = 1'b0;
        disarmReq = 1'b0;
    endtask

    initial begin
        int  sirenCycles;
        bit  sirenSeen;
        bit  leftArmed;
        int  guard;

        checkCnt  = 0;
        passCnt   = 0;
        reset     = 1'b1;
        lights    = 1'b0;
        doors     = 4'b0000;
        ign       = 1'b0;
        armReq    = 1'b0;
        disarmReq = 1'b0;

        // ---------------- reset state ----------------
        ticks(3);
        checkValue("rst_carAlarm", carAlarm, 0);
        checkValue("rst_siren",    siren,    0);
        checkValue("rst_armed",    armed,    0);
        checkValue("rst_state",    state,    0);
        reset = 1'b0;
        ticks(2);
        checkValue("post_rst_state",    state,    0);
        checkValue("post_rst_carAlarm", carAlarm, 0);
        checkValue("post_rst_armed",    armed,    0);

        // ---------------- lights warning ----------------
        lights = 1'b1;
        doors  = 4'b0100;
        ticks(4);                              // edges E0..E0+3
        checkValue("lights_E3", carAlarm, 0);
        tick();                                // E0+4
        checkValue("lights_E4", carAlarm, 1);

        // Arm with a debounced door open is dropped.
        pulse(1'b1, 1'b0);
        checkValue("arm_door_open", state, 0);

        ign = 1'b1;
        ticks(4);
        checkValue("ign_E3", carAlarm, 1);
        tick();
        checkValue("ign_E4", carAlarm, 0);

        lights = 1'b0;
        doors  = 4'b0000;
        ign    = 1'b0;
        ticks(8);

        // Arm and disarm together in DISARMED stays DISARMED.
        pulse(1'b1, 1'b1);
        checkValue("arm_disarm_idle", state, 0);

        // ---------------- arm ----------------
        pulse(1'b1, 1'b0);
        checkValue("arm_state", state, 1);
        checkValue("arm_armed", armed, 1);

        // ---------------- glitch rejection ----------------
        sirenSeen = 1'b0;
        leftArmed = 1'b0;
        doors     = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (siren) sirenSeen = 1'b1;
            if (state != 2'd1) leftArmed = 1'b1;
        end
        doors = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (siren) sirenSeen = 1'b1;
            if (state != 2'd1) leftArmed = 1'b1;
        end
        checkValue("glitch_left_armed", leftArmed, 0);
        checkValue("glitch_siren",      sirenSeen, 0);

        // ---------------- full alarm ----------------
        doors = 4'b0001;
        ticks(4);                              // E0+3
        checkValue("full_E3_armed", state, 1);
        tick();                                // E0+4
        checkValue("full_E4_entry", state, 2);
        ticks(15);                             // E0+19
        checkValue("full_E19_entry", state, 2);
        checkValue("full_E19_siren", siren, 0);
        tick();                                // E0+20
        checkValue("full_E20_alarm", state, 3);
        checkValue("full_E20_siren", siren, 1);
        sirenCycles = 1;
        guard       = 0;
        while (siren && guard < 200) begin
            tick();
            guard++;
            if (siren) sirenCycles++;
        end
        checkValue("siren_len",       sirenCycles, 64);
        checkValue("after_siren",     state,       1);
        checkValue("after_siren_arm", armed,       1);
        tick();
        checkValue("re_entry", state, 2);

        // ---------------- disarm race ----------------
        sirenSeen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (siren) sirenSeen = 1'b1;
        end
        checkValue("entry_10", state, 2);
        pulse(1'b0, 1'b1);
        checkValue("disarm_entry_state", state, 0);
        checkValue("disarm_entry_armed", armed, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (siren) sirenSeen = 1'b1;
        end
        checkValue("disarm_no_siren", sirenSeen, 0);
        checkValue("disarm_stays",    state,     0);

        doors = 4'b0000;
        ticks(6);
        pulse(1'b1, 1'b0);
        checkValue("rearm", state, 1);
        pulse(1'b1, 1'b1);
        checkValue("arm_disarm_armed", state, 0);

        // ---------------- async reset mid-ALARM ----------------
        pulse(1'b1, 1'b0);
        doors = 4'b1000;
        guard = 0;
        while (state != 2'd3 && guard < 100) begin
            tick();
            guard++;
        end
        checkValue("reach_alarm", state, 3);
        ticks(3);
        checkValue("alarm_siren", siren, 1);
        #2;                                    // between edges
        reset = 1'b1;
        #1;
        checkValue("async_siren", siren, 0);
        checkValue("async_state", state, 0);
        checkValue("async_armed", armed, 0);
        doors = 4'b0000;
        ticks(2);
        reset = 1'b0;
        ticks(2);
        checkValue("final_state", state, 0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
`default_nettype wire
